esn_output_packetizer: RTL and testbench
========================================

Name: esn_output_packetizer

Overview:
- Sits directly downstream of the ESN output neuron stage.
- Captures each one-cycle output-ready pulse with its 32-bit Q24 result.
- Rounds and saturates the result to 16-bit Q10 and buffers it in a small FIFO.
- Streams fixed-size byte frames to the Ethernet TX path over a valid/ready byte interface.

Parameters:
- DEPTH, 16: FIFO depth in samples; power of two, minimum 4.
- FRAME_SAMPLES, 4: samples per frame; must be 1 to DEPTH.
- HDR_BYTE, 8'hA5: first byte of every frame.

Ports:
- clk  in  1  ESN clock (125 MHz Ethernet clock)
- rst  in  1  synchronous, active-high reset
- y_in  in  32  signed ESN output, Q24 (<32,24>)
- y_valid  in  1  one-cycle pulse; y_in is valid in the same cycle
- tx_data  out  8  frame byte
- tx_valid  out  1  tx_data is valid
- tx_last  out  1  final byte of the frame, qualified by tx_valid
- tx_ready  in  1  downstream accepts the byte when tx_valid && tx_ready
- fifo_count  out  $clog2(DEPTH)+1  samples currently stored
- overflow  out  1  sticky; set on the first dropped sample, cleared only by rst
- drop_cnt  out  16  number of dropped samples; saturates at 16'hFFFF

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (rst).
- Reset values:
  - tx_valid=0, tx_last=0, tx_data=0.
  - fifo_count=0, overflow=0, drop_cnt=0.
  - Sequence counter=0, FSM in IDLE, quantizer stage register cleared.
- Quantize stage, registered, 1 cycle:
  - q = (y_in + 32'sd8192) >>> 14, computed at 33 bits signed so the add cannot wrap.
  - Result is saturated to [-32768, 32767].
  - The stage register latches q and a valid bit when y_valid=1.
- FIFO write:
  - Occurs on the edge after the stage register loads, so fifo_count increments 2 cycles after the y_valid pulse.
  - A write is accepted if fifo_count < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped: overflow<=1 and drop_cnt increments.
  - A simultaneous accepted push and pop leaves fifo_count unchanged.
- FIFO read/write pointers wrap modulo DEPTH.
- FSM states: IDLE, HDR, SEQ, DATA_HI, DATA_LO.
  - IDLE: when fifo_count >= FRAME_SAMPLES, go to HDR. tx_valid=0.
  - HDR: tx_data=HDR_BYTE. Advance to SEQ on handshake.
  - SEQ: tx_data=sequence counter. Advance to DATA_HI on handshake.
  - DATA_HI: tx_data = FIFO head [15:8]. Advance to DATA_LO on handshake.
  - DATA_LO: tx_data = FIFO head [7:0]. The FIFO pops on this handshake.
    - If samples sent in this frame < FRAME_SAMPLES, go to DATA_HI.
    - Otherwise assert tx_last on this byte, increment the sequence counter (8-bit, 255 wraps to 0), and go to IDLE.
- Frame length is 2 + 2*FRAME_SAMPLES bytes. Minimum of 1 idle cycle between frames.
- tx_data, tx_valid and tx_last are registered. They are held stable while tx_valid && !tx_ready.
- tx_valid never deasserts mid-frame without a handshake.
- Frame start is committed only when the full frame is already buffered, so DATA states never underflow.
- rst asserted mid-frame:
  - Aborts the frame immediately; no tx_last is emitted.
  - Empties the FIFO and restarts the sequence counter at 0.
- y_valid arriving during rst is ignored.

Test Plan:
- Single pulse per value, frame drained with tx_ready=1:
  - y_in=32'h01000000 (1.0) -> sample 16'h0400.
  - y_in=32'h00002000 -> 16'h0001 (rounds up).
  - y_in=32'hFFFFE000 -> 16'h0000.
  - y_in=32'hFFFFC000 -> 16'hFFFF.
- Saturation:
  - y_in=32'h7FFFFFFF -> 16'h7FFF.
  - y_in=32'h80000000 -> 16'h8000.
  - y_in=32'h08000000 (+8.0) -> 16'h2000 (no saturation).
- Frame content: FRAME_SAMPLES=4, inputs 1.0, 2.0, -1.0, 0.5, tx_ready=1.
  - Bytes A5,00,04,00,08,00,FC,00,02,00.
  - tx_last only on the 10th byte.
  - A second frame carries sequence byte 01.
- Backpressure: tx_ready toggles 1,0,0,1 per cycle.
  - tx_data stays stable during stalls.
  - Byte order and count are identical to the previous test.
  - fifo_count decrements only on DATA_LO handshakes.
- Overflow: tx_ready=0, 18 pulses spaced 10 cycles apart.
  - fifo_count reaches 16; FSM waits in HDR.
  - Pulses 17 and 18 are dropped: overflow=1, drop_cnt=2.
  - Then tx_ready=1: 4 frames emitted with sequence bytes 00-03; fifo_count returns to 0.
- Simultaneous push and pop while full: y_valid timed so the write lands on a DATA_LO handshake with fifo_count=16.
  - The sample is accepted and fifo_count stays 16.
  - drop_cnt is unchanged.
- Reset mid-frame: rst pulsed during DATA_HI of the 2nd sample.
  - Next cycle: tx_valid=0, fifo_count=0.
  - The next frame's sequence byte is 00.

Source files
------------

// File: rtl/esn_output_packetizer.sv
// ESN output packetizer: rounds Q24 results to saturated Q10, buffers them, and
// streams fixed-size byte frames (header, sequence, samples MSB-first) to Ethernet TX.
module esn_output_packetizer #(
  parameter int          DEPTH         = 16,
  parameter int          FRAME_SAMPLES = 4,
  parameter logic [7:0]  HDR_BYTE      = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                y_in,
  input  logic                       y_valid,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  output logic                       tx_last,
  input  logic                       tx_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic [15:0]                drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HDR     = 3'd1;
  localparam logic [2:0] SEQ     = 3'd2;
  localparam logic [2:0] DATA_HI = 3'd3;
  localparam logic [2:0] DATA_LO = 3'd4;

  // 33-bit add so the rounding offset can never wrap near +full-scale
  logic signed [32:0] sum, shr;
  logic [15:0]        q_sat;

  always_comb begin
    sum = $signed({y_in[31], y_in}) + 33'sd8192;
    shr = sum >>> 14;
    if (shr > 33'sd32767)       q_sat = 16'h7FFF;
    else if (shr < -33'sd32768) q_sat = 16'h8000;
    else                        q_sat = shr[15:0];
  end

  logic [15:0] q_reg;
  logic        q_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= '0;
      q_vld <= 1'b0;
    end else begin
      q_vld <= y_valid;
      if (y_valid) q_reg <= q_sat;
    end
  end

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [2:0]    state;
  logic [IW-1:0] idx;
  logic [7:0]    seq;
  logic          pop, push_ok;

  assign pop        = (state == DATA_LO) && tx_valid && tx_ready;
  // a pop on the same edge frees the slot the incoming sample needs
  assign push_ok    = q_vld && ((count < CW'(DEPTH)) || pop);
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= q_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (q_vld && !push_ok) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Outputs are registered; in every non-IDLE state tx_valid is high, so tx_ready alone is the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      seq      <= '0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: if (count >= CW'(FRAME_SAMPLES)) begin
          state    <= HDR;
          tx_valid <= 1'b1;
          tx_last  <= 1'b0;
          tx_data  <= HDR_BYTE;
          idx      <= '0;
        end
        HDR: if (tx_ready) begin
          state   <= SEQ;
          tx_data <= seq;
        end
        SEQ: if (tx_ready) begin
          state   <= DATA_HI;
          tx_data <= mem[rd_ptr][15:8];
        end
        DATA_HI: if (tx_ready) begin
          state   <= DATA_LO;
          tx_data <= mem[rd_ptr][7:0];
          tx_last <= (idx == IW'(FRAME_SAMPLES - 1));
        end
        DATA_LO: if (tx_ready) begin
          if (tx_last) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            seq      <= seq + 8'd1;
          end else begin
            // whole frame is buffered, so the next head is already valid
            state   <= DATA_HI;
            idx     <= idx + IW'(1);
            tx_data <= mem[rd_ptr + AW'(1)][15:8];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_esn_output_packetizer.sv
// Bench for esn_output_packetizer: directed test-plan values plus random traffic,
// scored against a queue-based frame model.
module tb_esn_output_packetizer;
  localparam int         DEPTH = 16;
  localparam int         FS    = 4;
  localparam logic [7:0] HDR   = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] y_in = '0;
  logic        y_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_last;
  logic        tx_ready = 1'b0;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic [15:0] drop_cnt;

  always #4 clk = ~clk;

  esn_output_packetizer #(.DEPTH(DEPTH), .FRAME_SAMPLES(FS), .HDR_BYTE(HDR)) dut (
    .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .fifo_count(fifo_count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  int checks = 0, errors = 0;

  // model state: buffered samples, byte position inside current frame
  logic [15:0] mq[$];
  int          pos = 0;
  logic [7:0]  mseq = '0;
  bit          movf = 0;
  int          mdrop = 0;
  bit          st_v = 0;
  logic [15:0] st_q = '0;
  bit          gap = 0, due = 0, rst_prev = 0;
  int          frames = 0, cyc = 0, rdy_mode = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // round-to-nearest of y/2^14 (ties up), clamped to int16
  function automatic logic [15:0] quant(logic [31:0] y);
    longint v, n, r;
    v = longint'($signed(y));
    n = v + 64'sd8192;
    r = (n >= 0) ? n / 16384 : -((-n + 16383) / 16384);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  task automatic model_edge();
    bit hs, pop;
    hs  = tx_valid && tx_ready;
    pop = 0;
    if (rst) begin
      mq.delete();
      pos = 0; mseq = '0; movf = 0; mdrop = 0;
      st_v = 0; st_q = '0; due = 0; gap = 0; rst_prev = 1;
    end else begin
      if (hs) begin
        if (pos == 2*FS + 1) begin
          pop = 1; pos = 0; mseq++; gap = 1; frames++;
        end else begin
          if (pos >= 3 && pos % 2 == 1) pop = 1;
          pos++;
        end
      end
      if (pop && mq.size() > 0) void'(mq.pop_front());
      if (st_v) begin
        if (mq.size() < DEPTH) mq.push_back(st_q);
        else begin
          movf = 1;
          if (mdrop < 65535) mdrop++;
        end
      end
      st_v = y_valid;
      st_q = quant(y_in);
    end
  endtask

  task automatic check();
    logic [7:0] eb;
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(movf));
    chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
    if (rst_prev) begin
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_last", 32'(tx_last), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
    end
    if (gap) chk("idle_gap", 32'(tx_valid), 32'd0);
    if (pos > 0)  chk("midframe_valid", 32'(tx_valid), 32'd1);
    else if (due) chk("frame_start", 32'(tx_valid), 32'd1);
    if (tx_valid) begin
      if (pos == 0) chk("frame_buffered", 32'(mq.size() >= FS), 32'd1);
      if (pos >= 2) chk("head_present", 32'(mq.size() > 0), 32'd1);
      if (pos == 0)           eb = HDR;
      else if (pos == 1)      eb = mseq;
      else if (mq.size() == 0) eb = 8'h00;
      else if (pos % 2 == 0)  eb = mq[0][15:8];
      else                    eb = mq[0][7:0];
      chk("tx_data", 32'(tx_data), 32'(eb));
      chk("tx_last", 32'(tx_last), 32'(pos == 2*FS + 1));
    end
    due = (pos == 0) && (mq.size() >= FS) && !tx_valid;
    gap = 0;
    rst_prev = 0;
  endtask

  task automatic step();
    if (rdy_mode == 1)      tx_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
    else if (rdy_mode == 2) tx_ready = 1'($urandom_range(0, 1));
    model_edge();
    @(negedge clk);
    cyc++;
    check();
  endtask

  task automatic pulse(logic [31:0] v, int spc);
    y_valid = 1'b1;
    y_in    = v;
    step();
    y_valid = 1'b0;
    y_in    = $urandom();
    repeat (spc - 1) step();
  endtask

  logic [31:0] dir_vals [12] = '{32'h01000000, 32'h00002000, 32'hFFFFE000, 32'hFFFFC000,
                                 32'h7FFFFFFF, 32'h80000000, 32'h08000000, 32'h00000000,
                                 32'h01000000, 32'h02000000, 32'hFF000000, 32'h00800000};
  logic [31:0] frm_vals [4]  = '{32'h01000000, 32'h02000000, 32'hFF000000, 32'h00800000};
  logic [31:0] edge_vals [6] = '{32'h7FFFFFFF, 32'h80000000, 32'h00001FFF, 32'hFFFFDFFF,
                                 32'h1FFFDFFF, 32'hE0000000};

  initial begin
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // directed rounding / saturation / frame-content values, tx_ready held high
    tx_ready = 1'b1;
    foreach (dir_vals[i]) pulse(dir_vals[i], 3);
    repeat (30) step();

    // same frame under 1,0,0,1 backpressure
    rdy_mode = 1;
    foreach (frm_vals[i]) pulse(frm_vals[i], 3);
    repeat (60) step();
    rdy_mode = 0;
    tx_ready = 1'b1;
    repeat (20) step();

    // overflow from a clean reset, FSM parked in HDR
    rst = 1'b1; step(); rst = 1'b0; step();
    tx_ready = 1'b0;
    for (int i = 0; i < 18; i++) pulse($urandom(), 10);
    chk("ovf_count", 32'(fifo_count), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drops", 32'(drop_cnt), 32'd2);

    // write timed to land on the first DATA_LO pop while full
    tx_ready = 1'b1;
    step();
    step();
    y_valid = 1'b1; y_in = $urandom();
    step();
    y_valid = 1'b0;
    step();
    chk("pushpop_count", 32'(fifo_count), 32'd16);
    chk("pushpop_drops", 32'(drop_cnt), 32'd2);
    repeat (200) step();
    for (int i = 0; i < 3; i++) pulse($urandom(), 3);
    repeat (40) step();
    chk("drained", 32'(fifo_count), 32'd0);

    // random traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      y_valid = ($urandom_range(0, 3) == 0);
      y_in    = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom();
      step();
    end
    y_valid  = 1'b0;
    rdy_mode = 0;
    tx_ready = 1'b1;
    repeat (60) step();

    // reset during DATA_HI of the second sample
    for (int i = 0; i < FS; i++) pulse($urandom(), 2);
    for (int k = 0; k < 100 && !(pos == 4 && tx_valid); k++) step();
    chk("reach_data_hi2", 32'(pos == 4 && tx_valid), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < FS; i++) pulse($urandom(), 2);
    repeat (40) step();

    chk("frames_seen", 32'(frames >= 8), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
